// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants for the forwarding scoreboard: operand-mux encodings and
// default pipeline geometry.
package fwd_scoreboard_pkg;

    localparam int FWD_RF       = 0;
    localparam int DEF_NREG     = 32;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_CNTW     = 16;

endpackage

// File: rtl/fwd_scoreboard_sb_match.sv
// Priority matcher: finds the youngest valid in-flight entry whose destination
// equals the requested source register.
module sb_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEF_NREG),
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]         ent_v,
    input  logic [DEPTH-1:0][AW-1:0] ent_rd,
    input  logic [DEPTH-1:0]         ent_ld,
    input  logic [AW-1:0]            src,
    input  logic                     used,
    output logic                     hit,
    output logic [FW-1:0]            index,
    output logic                     ld
);

    // Scan oldest to youngest so the lowest stage index overrides any older hit.
    // x0 is hardwired to zero and never participates.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        ld    = 1'b0;
        if (used && (src != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_v[k] && (ent_rd[k] == src)) begin
                    hit   = 1'b1;
                    index = FW'(k);
                    ld    = ent_ld[k];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard beside ID: tracks in-flight destinations for
// DEPTH stages, selects operand sources, and raises load-use stalls.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter  int NREG     = DEF_NREG,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int LOAD_LAT = DEF_LOAD_LAT,
    parameter  int CNTW     = DEF_CNTW,
    localparam int AW       = $clog2(NREG),
    localparam int FW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_regwr,
    input  logic            id_isload,
    input  logic            flush,
    output logic            issue,
    output logic            stall,
    output logic [FW-1:0]   rs1_fwd,
    output logic            rs1_fwd_ld,
    output logic [FW-1:0]   rs2_fwd,
    output logic            rs2_fwd_ld,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [FW-1:0] LL = FW'(LOAD_LAT);

    logic [DEPTH-1:0]         ent_v;
    logic [DEPTH-1:0][AW-1:0] ent_rd;
    logic [DEPTH-1:0]         ent_ld;

    logic          hit1, hit2, ld1, ld2;
    logic [FW-1:0] idx1, idx2;
    logic          hazard, stall_i, issue_i;

    sb_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_match_rs1 (
        .ent_v  (ent_v),
        .ent_rd (ent_rd),
        .ent_ld (ent_ld),
        .src    (id_rs1),
        .used   (id_rs1_used),
        .hit    (hit1),
        .index  (idx1),
        .ld     (ld1)
    );

    sb_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_match_rs2 (
        .ent_v  (ent_v),
        .ent_rd (ent_rd),
        .ent_ld (ent_ld),
        .src    (id_rs2),
        .used   (id_rs2_used),
        .hit    (hit2),
        .index  (idx2),
        .ld     (ld2)
    );

    // Load data only becomes forwardable from stage LOAD_LAT onward; flush wins
    // over stall, and everything is held quiet while reset is asserted.
    always_comb begin
        hazard     = (hit1 & ld1 & (idx1 < LL)) | (hit2 & ld2 & (idx2 < LL));
        stall_i    = rst & id_valid & hazard & ~flush;
        issue_i    = rst & id_valid & ~hazard & ~flush;
        stall      = stall_i;
        issue      = issue_i;
        rs1_fwd    = (rst && hit1) ? idx1 + FW'(1) : FW'(FWD_RF);
        rs2_fwd    = (rst && hit2) ? idx2 + FW'(1) : FW'(FWD_RF);
        rs1_fwd_ld = rst & hit1 & ld1;
        rs2_fwd_ld = rst & hit2 & ld2;
    end

    // The stage shift never freezes; a stalled or flushed ID cycle becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_v  <= '0;
            ent_rd <= '0;
            ent_ld <= '0;
        end else begin
            ent_v[0]  <= issue_i & id_regwr & (id_rd != '0);
            ent_rd[0] <= id_rd;
            ent_ld[0] <= id_isload;
            for (int k = 1; k < DEPTH; k++) begin
                ent_v[k]  <= ent_v[k-1];
                ent_rd[k] <= ent_rd[k-1];
                ent_ld[k] <= ent_ld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule
